puf_eval_sequencer: RTL and testbench

- Controller for one PUF parallel subblock, i.e. two 16-RO banks, two 16:1 muxes, post-mux counters and race arbiter.
- Accepts a response request: a base challenge and a bit count. For each bit it clears the subblock, drives the challenge and RO enables, and waits for the arbiter's done. It then captures the arbiter output bit.
- Returns a packed multi-bit response over a valid/ready handshake.
- Sits between the host/UART command logic and the subblock instance.

---
 rtl/puf_eval_sequencer.sv | 157 +++++++++++++++
 tb/tb_puf_eval_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_eval_sequencer.sv
// Response sequencer for one PUF parallel subblock: clears the RO banks, drives
// challenge/enables, collects one arbiter bit per evaluation and packs a response.
module puf_eval_sequencer #(
  parameter int unsigned RESP_W  = 16,
  parameter int unsigned CLR_CYC = 4,
  parameter int unsigned TIMEOUT = 24'hFFFFFF,
  parameter logic [7:0]  CH_STEP = 8'd1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [7:0]                   base_challenge,
  input  logic [$clog2(RESP_W+1)-1:0]  num_bits,
  output logic                         busy,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [RESP_W-1:0]            response,
  output logic                         resp_error,
  output logic [7:0]                   puf_challenge,
  output logic [31:0]                  puf_enable,
  output logic                         puf_reset,
  input  logic                         puf_out,
  input  logic                         puf_done
);

  localparam int NW = $clog2(RESP_W + 1);
  localparam int IW = $clog2(RESP_W);
  localparam int CW = $clog2(CLR_CYC);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, EVAL, RESP} state_t;

  state_t          state_q, state_d;
  logic            out_s1, out_s, done_s1, done_s;
  logic [NW-1:0]   n_q;
  logic [NW-1:0]   n_eff;
  logic [IW-1:0]   bit_idx;
  logic [CW-1:0]   clr_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            armed;
  logic            accept, expire, last_bit, clr_done;
  logic [31:0]     enable_d;
  logic            puf_reset_d;

  // Bit 0 gates the counters and arbiter, so it is on for every evaluation.
  function automatic logic [31:0] enable_map(input logic [7:0] ch);
    logic [31:0] en;
    en = 32'h1;
    en = en | (32'h1 << ch[3:0]) | (32'h1 << (5'd16 + {1'b0, ch[7:4]}));
    return en;
  endfunction

  assign n_eff    = (num_bits > NW'(RESP_W)) ? NW'(RESP_W) : num_bits;
  assign clr_done = (clr_cnt == CW'(CLR_CYC - 1));
  assign expire   = (tmo_cnt == TW'(TIMEOUT - 1));
  assign accept   = (state_q == EVAL) && armed && done_s;
  assign last_bit = (NW'(bit_idx) == (n_q - NW'(1)));

  // Arbiter outputs are asynchronous to clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_s1  <= 1'b0;
      out_s   <= 1'b0;
      done_s1 <= 1'b0;
      done_s  <= 1'b0;
    end else begin
      out_s1  <= puf_out;
      out_s   <= out_s1;
      done_s1 <= puf_done;
      done_s  <= done_s1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = (n_eff == '0) ? RESP : CLEAR;
      CLEAR: if (clr_done) state_d = EVAL;
      EVAL: begin
        if (accept)      state_d = last_bit ? RESP : CLEAR;
        else if (expire) state_d = RESP;
      end
      RESP:  if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    resp_valid  = (state_q == RESP);
    enable_d    = (state_d == EVAL) ? enable_map(puf_challenge) : 32'h0;
    puf_reset_d = (state_d != EVAL);
  end

  // Subblock drive is registered so it lines up exactly with the EVAL state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      puf_enable <= 32'h0;
      puf_reset  <= 1'b1;
    end else begin
      puf_enable <= enable_d;
      puf_reset  <= puf_reset_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      puf_challenge <= 8'h00;
      n_q           <= '0;
      bit_idx       <= '0;
      response      <= '0;
      resp_error    <= 1'b0;
      clr_cnt       <= '0;
      tmo_cnt       <= '0;
      armed         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            puf_challenge <= base_challenge;
            n_q           <= n_eff;
            bit_idx       <= '0;
            response      <= '0;
            resp_error    <= 1'b0;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_done ? '0 : clr_cnt + CW'(1);
          tmo_cnt <= '0;
          armed   <= 1'b0;
        end
        EVAL: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          // A done still high from the previous bit is ignored until it drops.
          if (!armed && !done_s) armed <= 1'b1;
          if (accept) begin
            response[bit_idx] <= out_s;
            if (!last_bit) begin
              bit_idx       <= bit_idx + IW'(1);
              puf_challenge <= puf_challenge + CH_STEP;
            end
          end else if (expire) begin
            resp_error        <= 1'b1;
            response[bit_idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Directed bench for puf_eval_sequencer with a behavioural subblock stub.
module tb_puf_eval_sequencer;
  localparam int RESP_W = 16;
  localparam int NW     = $clog2(RESP_W + 1);

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset, start, resp_ready, puf_out, puf_done;
  logic [7:0]        base_challenge;
  logic [NW-1:0]     num_bits;
  logic              busy_a, resp_valid_a, resp_error_a, puf_reset_a;
  logic [RESP_W-1:0] response_a;
  logic [7:0]        puf_challenge_a;
  logic [31:0]       puf_enable_a;
  logic              busy_b, resp_valid_b, resp_error_b, puf_reset_b;
  logic [RESP_W-1:0] response_b;
  logic [7:0]        puf_challenge_b;
  logic [31:0]       puf_enable_b;

  puf_eval_sequencer #(.RESP_W(RESP_W), .CLR_CYC(4), .TIMEOUT(100), .CH_STEP(8'd1)) dut_a (
    .clock(clock), .reset(reset), .start(start), .base_challenge(base_challenge),
    .num_bits(num_bits), .busy(busy_a), .resp_valid(resp_valid_a), .resp_ready(resp_ready),
    .response(response_a), .resp_error(resp_error_a), .puf_challenge(puf_challenge_a),
    .puf_enable(puf_enable_a), .puf_reset(puf_reset_a), .puf_out(puf_out), .puf_done(puf_done)
  );

  puf_eval_sequencer #(.RESP_W(RESP_W), .CLR_CYC(4), .TIMEOUT(100), .CH_STEP(8'd3)) dut_b (
    .clock(clock), .reset(reset), .start(start), .base_challenge(base_challenge),
    .num_bits(num_bits), .busy(busy_b), .resp_valid(resp_valid_b), .resp_ready(resp_ready),
    .response(response_b), .resp_error(resp_error_b), .puf_challenge(puf_challenge_b),
    .puf_enable(puf_enable_b), .puf_reset(puf_reset_b), .puf_out(puf_out), .puf_done(puf_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Stub configuration (written by the stimulus process only)
  int          stub_delay;
  bit          stub_stale;
  int          never_bit;
  logic [31:0] stub_pat;
  int          clr_req;

  // Monitor state (written by the stub/monitor process only)
  int          evals, eval_cyc, clr_run, eval_len, mon_ack;
  bit          prev_rst_a, prev_rst_b, any_en;
  logic [7:0]  chal_a[$];
  logic [7:0]  chal_b[$];
  logic [31:0] en_a[$];
  logic [31:0] en_b[$];
  int          clr_q[$];
  int          len_q[$];

  initial begin
    puf_out = 1'b0; puf_done = 1'b0;
    evals = 0; eval_cyc = 0; clr_run = 0; eval_len = 0; mon_ack = 0;
    prev_rst_a = 1'b1; prev_rst_b = 1'b1; any_en = 1'b0;
    forever begin
      @(negedge clock);
      if (mon_ack != clr_req) begin
        mon_ack = clr_req;
        chal_a.delete(); chal_b.delete(); en_a.delete(); en_b.delete();
        clr_q.delete(); len_q.delete();
        evals = 0; clr_run = 0; eval_len = 0; any_en = 1'b0;
      end
      if (prev_rst_a && !puf_reset_a) begin
        chal_a.push_back(puf_challenge_a); en_a.push_back(puf_enable_a); evals++;
      end
      if (prev_rst_b && !puf_reset_b) begin
        chal_b.push_back(puf_challenge_b); en_b.push_back(puf_enable_b);
      end
      if (!puf_reset_a) eval_len++;
      else if (!prev_rst_a) begin len_q.push_back(eval_len); eval_len = 0; end
      if (busy_a && puf_reset_a && !resp_valid_a) clr_run++;
      else if (clr_run > 0) begin clr_q.push_back(clr_run); clr_run = 0; end
      if (puf_enable_a != 32'h0) any_en = 1'b1;
      prev_rst_a = puf_reset_a;
      prev_rst_b = puf_reset_b;
      // Subblock stub: done/out evolve from the moment the clear is released.
      if (puf_reset_a) begin
        eval_cyc = 0; puf_done = stub_stale; puf_out = 1'b0;
      end else begin
        eval_cyc++;
        if (stub_stale) begin
          puf_done = (eval_cyc <= 10) || (eval_cyc >= 30);
          puf_out  = (eval_cyc >= 30);
        end else begin
          puf_done = (eval_cyc >= stub_delay) && ((evals - 1) != never_bit);
          puf_out  = stub_pat[(evals - 1) & 31];
        end
      end
    end
  end

  function automatic logic [31:0] chal_word(input bit use_b);
    logic [31:0] w;
    int n;
    w = 32'h0;
    n = use_b ? chal_b.size() : chal_a.size();
    for (int i = 0; i < n && i < 4; i++)
      w = w | (32'(use_b ? chal_b[i] : chal_a[i]) << (8 * i));
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic request(input logic [7:0] b, input int nb);
    clr_req++;
    base_challenge = b;
    num_bits = NW'(nb);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k;
    k = 0;
    while (!resp_valid_a && k < budget) begin @(negedge clock); k++; end
    check({tag, " valid in time"}, 32'(resp_valid_a), 32'h1);
    #1;
  endtask

  task automatic accept();
    @(posedge clock); #1;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    int good, stable, k;
    logic v0, v1;
    reset = 1'b1; start = 1'b0; base_challenge = 8'h00; num_bits = '0; resp_ready = 1'b0;
    stub_delay = 50; stub_stale = 1'b0; never_bit = -1; stub_pat = 32'h0; clr_req = 0;
    #2 reset = 1'b0;
    tick(3);
    @(negedge clock);
    check("rst busy",      32'(busy_a),          32'h0);
    check("rst valid",     32'(resp_valid_a),    32'h0);
    check("rst response",  32'(response_a),      32'h0);
    check("rst error",     32'(resp_error_a),    32'h0);
    check("rst challenge", 32'(puf_challenge_a), 32'h0);
    check("rst enable",    puf_enable_a,         32'h0);
    check("rst puf_reset", 32'(puf_reset_a),     32'h1);
    reset = 1'b1;
    tick(2);

    // Single request, four bits
    stub_pat = 32'hD;
    request(8'h00, 4);
    wait_valid("t1", 2000);
    check("t1 response",   32'(response_a),   32'h000D);
    check("t1 error",      32'(resp_error_a), 32'h0);
    check("t1 eval count", 32'(chal_a.size()), 32'd4);
    check("t1 challenges", chal_word(1'b0),   32'h03020100);
    check("t1 enable ch00", en_a[0],          32'h0001_0001);
    check("t1 enable ch01", en_a[1],          32'h0001_0003);
    good = 0;
    foreach (clr_q[i]) if (clr_q[i] == 4) good++;
    check("t1 clear runs", 32'(clr_q.size()), 32'd4);
    check("t1 clear len4", 32'(good),         32'd4);
    accept();

    // Challenge stepping and wrap
    request(8'hFE, 3);
    wait_valid("t2", 2000);
    check("t2 step3 challenges", chal_word(1'b1), 32'h000401FE);
    check("t2 step1 challenges", chal_word(1'b0), 32'h0000FFFE);
    check("t2 enable ch04",      en_b[2],         32'h0001_0011);
    check("t2 response a",       32'(response_a), 32'h0005);
    check("t2 response b",       32'(response_b), 32'h0005);
    accept();

    // Timeout on bit 1
    stub_pat = 32'h1; never_bit = 1;
    request(8'h20, 3);
    wait_valid("t3", 2000);
    check("t3 error",      32'(resp_error_a),   32'h1);
    check("t3 response",   32'(response_a),     32'h0001);
    check("t3 eval count", 32'(chal_a.size()),  32'd2);
    check("t3 bit1 cycles", 32'(len_q.size() > 1 ? len_q[1] : -1), 32'd100);
    accept();
    never_bit = -1;

    // Stale done, ignored starts, backpressure
    stub_stale = 1'b1;
    request(8'h00, 2);
    tick(10);
    base_challenge = 8'h55; num_bits = NW'(1); start = 1'b1;
    tick(1); start = 1'b0;
    tick(10);
    start = 1'b1;
    tick(1); start = 1'b0;
    wait_valid("t4", 2000);
    check("t4 response",   32'(response_a),    32'h0003);
    check("t4 error",      32'(resp_error_a),  32'h0);
    check("t4 challenges", chal_word(1'b0),    32'h00000100);
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      start = (i == 5);
      @(negedge clock);
      if (resp_valid_a && response_a == 16'h0003 && !resp_error_a) stable++;
    end
    check("t4 held 20 cycles", 32'(stable), 32'd20);
    @(posedge clock); #1;
    resp_ready = 1'b1; start = 1'b1; base_challenge = 8'h77; num_bits = NW'(2);
    @(posedge clock); #1;
    resp_ready = 1'b0; start = 1'b0;
    tick(3);
    @(negedge clock);
    check("t4 start on exit ignored", 32'(busy_a), 32'h0);
    check("t4 valid cleared",         32'(resp_valid_a), 32'h0);
    stub_stale = 1'b0;
    tick(1);

    // Zero-length request
    clr_req++;
    base_challenge = 8'hAA; num_bits = '0; start = 1'b1;
    @(negedge clock); v0 = resp_valid_a;
    @(posedge clock); #1; start = 1'b0;
    @(negedge clock); v1 = resp_valid_a;
    check("t5 n0 not early", 32'(v0), 32'h0);
    check("t5 n0 valid",     32'(v1), 32'h1);
    check("t5 n0 response",  32'(response_a), 32'h0);
    check("t5 n0 error",     32'(resp_error_a), 32'h0);
    #1;
    accept();
    check("t5 n0 enable idle", 32'(any_en), 32'h0);

    // Oversized request clamps to RESP_W
    stub_delay = 5; stub_pat = 32'h9249;
    request(8'h00, 31);
    wait_valid("t5b", 3000);
    check("t5 clamp evals",    32'(chal_a.size()), 32'd16);
    check("t5 clamp response", 32'(response_a),    32'h9249);
    check("t5 clamp error",    32'(resp_error_a),  32'h0);
    accept();

    // Reset mid-evaluation of bit 2
    stub_delay = 20; stub_pat = 32'hF;
    request(8'h10, 4);
    k = 0;
    while (evals < 3 && k < 1000) begin @(negedge clock); k++; end
    check("t6 reached bit2", 32'(evals), 32'd3);
    tick(5);
    check("t6 pre-reset response", 32'(response_a), 32'h0003);
    #2 reset = 1'b0;
    #1;
    check("t6 busy",      32'(busy_a),       32'h0);
    check("t6 valid",     32'(resp_valid_a), 32'h0);
    check("t6 enable",    puf_enable_a,      32'h0);
    check("t6 puf_reset", 32'(puf_reset_a),  32'h1);
    check("t6 response",  32'(response_a),   32'h0);
    @(negedge clock); reset = 1'b1;
    tick(2);
    stub_pat = 32'h2;
    request(8'h10, 2);
    wait_valid("t6 again", 2000);
    check("t6 new response",   32'(response_a),   32'h0002);
    check("t6 new error",      32'(resp_error_a), 32'h0);
    check("t6 new challenges", chal_word(1'b0),   32'h00001110);
    accept();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
